// File: rtl/line_fill_mem_if.sv
// Request / refill bus between the cache miss path (master) and the
// line-fill memory (slave).
//
// Handshake: a request is taken on a rising clock edge when req_ready is 1
// and req_rd or req_we is 1. When both are 1, the read is taken and the write
// is dropped. While req_ready is 0, requests are ignored and not queued. The
// refill stream has no back-pressure: each cycle with mem_valid=1 carries one
// word. mem_last marks the final word of a line. mem_err flags an
// out-of-range access.
interface line_fill_mem_if;
  logic        req_rd;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic [31:0] mem_data;
  logic        mem_valid;
  logic        mem_last;
  logic        mem_err;

  modport master (
    output req_rd, req_we, req_addr, req_wdata,
    input  req_ready, mem_data, mem_valid, mem_last, mem_err
  );

  modport slave (
    input  req_rd, req_we, req_addr, req_wdata,
    output req_ready, mem_data, mem_valid, mem_last, mem_err
  );
endinterface

// File: rtl/line_fill_mem.sv
// Backing memory for the cache refill path.
// A write stores one word. A read returns a whole line, critical word first,
// and wraps inside the line. The first word arrives LATENCY cycles after the
// read is accepted.
// Optional macro LINE_FILL_MEM_RANGE_CHK_EN flags addresses that have nonzero
// bits above the store. Without the macro, those addresses alias and mem_err
// stays 0.
module line_fill_mem #(
  parameter int ADDR_W     = 8,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 4
) (
  input  logic             gclk,
  input  logic             rst,
  line_fill_mem_if.slave   bus,
  output logic [1:0]       dbg_state_o
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, BURST = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OFF_W-1:0]    k_q, k_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                oor_q, oor_d;
  logic [31:0]         data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic                wr_en;

  logic [31:0]         mem_q [2**ADDR_W];

  logic [ADDR_W-1:0]   widx;
  logic [OFF_W-1:0]    lane;
  logic [ADDR_W-1:0]   rd_idx;
  logic [31:0]         beat_word;
  logic                oor;

  assign widx = bus.req_addr[ADDR_W+1:2];

`ifdef LINE_FILL_MEM_RANGE_CHK_EN
  assign oor = |bus.req_addr[31:ADDR_W+2];
  logic unused_addr;
  assign unused_addr = ^bus.req_addr[1:0];
`else
  // With oor held at 0, err_q never sets and mem_err is a constant 0.
  assign oor = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};
`endif

  // The lane wraps modulo LINE_WORDS, so a burst never leaves its line.
  assign lane      = off_q + k_q;
  assign rd_idx    = base_q | {{(ADDR_W-OFF_W){1'b0}}, lane};
  assign beat_word = oor_q ? 32'hDEAD_BEEF : mem_q[rd_idx];

  // State register and registered outputs.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      off_q   <= '0;
      base_q  <= '0;
      oor_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      off_q   <= off_d;
      base_q  <= base_d;
      oor_q   <= oor_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Next state: a read starts the latency wait, and the burst follows it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_rd) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = BURST;
      BURST:   if (last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the request, count down the latency, then stream the line.
  always_comb begin
    cnt_d   = cnt_q;
    k_d     = k_q;
    off_d   = off_q;
    base_d  = base_q;
    oor_d   = oor_q;
    data_d  = data_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_rd) begin
          base_d = {widx[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          off_d  = widx[OFF_W-1:0];
          oor_d  = oor;
          cnt_d  = CNT_W'(LATENCY - 1);
          k_d    = '0;
        end else if (bus.req_we) begin
          if (oor) err_d = 1'b1;
          else     wr_en = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          data_d  = beat_word;
          valid_d = 1'b1;
          err_d   = oor_q;
          k_d     = k_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      BURST: begin
        if (!last_q) begin
          data_d  = beat_word;
          valid_d = 1'b1;
          last_d  = (k_q == OFF_W'(LINE_WORDS - 1));
          err_d   = oor_q;
          k_d     = k_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs: ready follows IDLE, so an asynchronous reset raises it at once.
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.mem_data  = data_q;
    bus.mem_valid = valid_q;
    bus.mem_last  = last_q;
    bus.mem_err   = err_q;
    dbg_state_o   = state_q;
  end

  // Word store. It has no reset, so its contents are undefined until written.
  always_ff @(posedge gclk) begin
    if (wr_en) mem_q[widx] <= bus.req_wdata;
  end

endmodule

// File: tb/tb_line_fill_mem.sv
module tb_line_fill_mem;
  logic       gclk;
  logic       rst;
  logic [1:0] dbg_state;
  int         tests_run;
  int         tests_failed;

  line_fill_mem_if bus ();

  line_fill_mem dut (
    .gclk        (gclk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog.
  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
    bus.req_addr  = addr;
    bus.req_wdata = data;
    bus.req_we    = 1'b1;
    bus.req_rd    = 1'b0;
    @(posedge gclk); #1;
    bus.req_we = 1'b0;
    chk("wr_ready", {31'b0, bus.req_ready}, 32'd1);
    if (exp_err) begin
      chk("wr_err_pulse", {31'b0, bus.mem_err}, 32'd1);
      @(posedge gclk); #1;
      chk("wr_err_clear", {31'b0, bus.mem_err}, 32'd0);
    end
  endtask

  // Issue a read. Check the 4-cycle gap, the four words, and the return to idle.
  task automatic do_read(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3,
                         input logic exp_err, input logic hold_rd);
    logic [31:0] exp_w [4];
    exp_w = '{w0, w1, w2, w3};
    bus.req_addr  = addr;
    bus.req_rd    = 1'b1;
    bus.req_we    = we;
    bus.req_wdata = wd;
    @(posedge gclk); #1;
    bus.req_rd = hold_rd;
    bus.req_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge gclk);
      chk("wait_valid", {31'b0, bus.mem_valid}, 32'd0);
      chk("wait_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge gclk);
      chk("burst_valid", {31'b0, bus.mem_valid}, 32'd1);
      chk("burst_data", bus.mem_data, exp_w[k]);
      chk("burst_last", {31'b0, bus.mem_last}, (k == 3) ? 32'd1 : 32'd0);
      chk("burst_err", {31'b0, bus.mem_err}, {31'b0, exp_err});
      chk("burst_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    bus.req_rd = 1'b0;
    @(negedge gclk);
    chk("done_valid", {31'b0, bus.mem_valid}, 32'd0);
    chk("done_last", {31'b0, bus.mem_last}, 32'd0);
    chk("done_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("done_hold", bus.mem_data, w3);
    @(negedge gclk);
    chk("no_rerun", {31'b0, bus.mem_valid}, 32'd0);
  endtask

  // Directed sequence.
  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst           = 1'b1;
    bus.req_rd    = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #3;
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_valid", {31'b0, bus.mem_valid}, 32'd0);
    chk("rst_last", {31'b0, bus.mem_last}, 32'd0);
    chk("rst_data", bus.mem_data, 32'd0);
    chk("rst_err", {31'b0, bus.mem_err}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, 32'd0);
    #20 rst = 1'b0;
    @(negedge gclk);

    for (int i = 0; i < 8; i++) do_write(32'(i * 4), 32'h1000_0000 + 32'(i), 1'b0);
    for (int i = 252; i < 256; i++) do_write(32'(i * 4), 32'h2000_0000 + 32'(i), 1'b0);

    do_read(32'h0000_0000, 1'b0, 32'h0,
            32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003, 1'b0, 1'b0);
    do_read(32'h0000_0018, 1'b0, 32'h0,
            32'h1000_0006, 32'h1000_0007, 32'h1000_0004, 32'h1000_0005, 1'b0, 1'b0);
    // Read and write together: the read wins.
    do_read(32'h0000_0008, 1'b1, 32'hAAAA_AAAA,
            32'h1000_0002, 32'h1000_0003, 32'h1000_0000, 32'h1000_0001, 1'b0, 1'b0);
    // req_rd is held through the burst, and the dropped write is checked here.
    do_read(32'h0000_0008, 1'b0, 32'h0,
            32'h1000_0002, 32'h1000_0003, 32'h1000_0000, 32'h1000_0001, 1'b0, 1'b1);

    // Asynchronous reset during the second burst word.
    bus.req_addr = 32'h0000_0000;
    bus.req_rd   = 1'b1;
    @(posedge gclk); #1;
    bus.req_rd = 1'b0;
    repeat (5) @(posedge gclk);
    #2;
    chk("mid_valid", {31'b0, bus.mem_valid}, 32'd1);
    chk("mid_data", bus.mem_data, 32'h1000_0001);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, bus.mem_valid}, 32'd0);
    chk("arst_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("arst_last", {31'b0, bus.mem_last}, 32'd0);
    chk("arst_state", {30'b0, dbg_state}, 32'd0);
    #1 rst = 1'b0;
    do_read(32'h0000_0004, 1'b0, 32'h0,
            32'h1000_0001, 32'h1000_0002, 32'h1000_0003, 32'h1000_0000, 1'b0, 1'b0);

`ifdef LINE_FILL_MEM_RANGE_CHK_EN
    do_write(32'hFFFF_FFF0, 32'h0000_0BAD, 1'b1);
    do_read(32'hFFFF_FFFF, 1'b0, 32'h0,
            32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0);
    do_read(32'h0000_03F0, 1'b0, 32'h0,
            32'h2000_00FC, 32'h2000_00FD, 32'h2000_00FE, 32'h2000_00FF, 1'b0, 1'b0);
`else
    do_read(32'hFFFF_FFFF, 1'b0, 32'h0,
            32'h2000_00FF, 32'h2000_00FC, 32'h2000_00FD, 32'h2000_00FE, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
